cache_mem_arbiter: RTL and testbench

//  Shares the single 256-bit RAM line port between the icache refill path and the dcache

---
 rtl/cache_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Shares one full-line RAM port between the icache refill path and the
// dcache refill / write-back path. One 32-byte line per transaction:
// arbitrate, hold the RAM request until it responds, return the line with a
// one-cycle ack, then wait for the RAM to drop its response (four-phase).
//
// Handshake contract:
//   i_req/d_req are levels held until the matching ack and dropped the cycle
//   after it; they are sampled only in IDLE. mem_en is held (with stable
//   mem_we/mem_addr/mem_wdata) until mem_resp is seen or the watchdog fires.
//   mem_resp must return low before the next grant is made.
module cache_mem_arbiter #(
  parameter int LINE_W      = 256,
  parameter int ADDR_W      = 32,
  parameter int OFFSET_W    = 5,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_line_o,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_line_o,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              busy,
  output logic              timeout_err,
  output logic [1:0]        fsm_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFFSET_W) - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t             state;
  logic               rr_ptr;    // 0: icache wins a tie, 1: dcache wins
  logic               grant_d;   // side owning the current transaction
  logic [CNT_W-1:0]   wait_cnt;
  logic               pick_d;
  logic [ADDR_W-1:0]  sel_addr;

  // Arbitration decision, only meaningful while IDLE
  always_comb begin
    pick_d   = d_req && (!i_req || rr_ptr);
    sel_addr = pick_d ? d_addr : i_addr;
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // Transaction FSM with all RAM-side and cache-side outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      grant_d     <= 1'b0;
      wait_cnt    <= '0;
      i_line_o    <= '0;
      d_line_o    <= '0;
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            grant_d   <= pick_d;
            if (i_req && d_req) rr_ptr <= ~pick_d;
            mem_addr  <= sel_addr & LINE_MASK;
            mem_we    <= pick_d && d_we;
            mem_wdata <= (pick_d && d_we) ? d_wdata : '0;
            mem_en    <= 1'b1;
            wait_cnt  <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp) begin
            // Write-backs leave the returned line untouched
            if (!mem_we) begin
              if (grant_d) d_line_o <= mem_rdata;
              else         i_line_o <= mem_rdata;
            end
            mem_en <= 1'b0;
            i_ack  <= !grant_d;
            d_ack  <= grant_d;
            state  <= DONE;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            // Abort but still ack so the requesting cache cannot hang
            timeout_err <= 1'b1;
            mem_en      <= 1'b0;
            i_ack       <= !grant_d;
            d_ack       <= grant_d;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          state <= RELEASE;
        end
        RELEASE: begin
          if (!mem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed-plus-random bench for cache_mem_arbiter. A transaction-level
// model tracks the tie-break pointer, the lines each cache should hold and
// the sticky timeout flag; every DUT observation is compared against it.
module tb_cache_mem_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;
  localparam int TO = 8;

  // Clock / reset
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  always #5 clk = ~clk;

  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_resp = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [LW-1:0] d_wdata = '0, mem_rdata = '0;
  logic [LW-1:0] i_line_o, d_line_o, mem_wdata;
  logic          i_ack, d_ack, mem_en, mem_we, busy, timeout_err;
  logic [AW-1:0] mem_addr;
  logic [1:0]    fsm_state;

  cache_mem_arbiter #(.LINE_W(LW), .ADDR_W(AW), .OFFSET_W(5), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_line_o(i_line_o), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_line_o(d_line_o), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .busy(busy), .timeout_err(timeout_err), .fsm_state(fsm_state)
  );

  // Scoreboard counters and reference model state
  int            n_checks = 0;
  int            n_pass   = 0;
  logic          m_rr     = 1'b0;
  logic [LW-1:0] m_i_line = '0;
  logic [LW-1:0] m_d_line = '0;
  logic          m_terr   = 1'b0;
  logic [AW-1:0] exp_q[$];   // expected mem_addr per grant

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drive one transaction from grant to ack. d < 0 means the RAM never answers.
  task automatic serve(input int d, input int hold, input logic [LW-1:0] rdata, input int exp_lat);
    logic          g;
    logic          ew;
    logic [LW-1:0] ewd;
    logic [AW-1:0] ea;
    int            cyc;
    if (i_req && d_req) begin
      g    = m_rr;
      m_rr = ~g;
    end else begin
      g = d_req;
    end
    exp_q.push_back((g ? d_addr : i_addr) & 32'hFFFF_FFE0);
    ew  = g & d_we;
    ewd = (g & d_we) ? d_wdata : '0;
    cyc = 0;
    while (!mem_en && cyc < 40) begin tick(); cyc++; end
    if (exp_lat > 0) check("grant_latency", LW'(cyc), LW'(exp_lat));
    ea = exp_q.pop_front();
    check("mem_en_on", mem_en, 1'b1);
    check("mem_addr", mem_addr, ea);
    check("mem_we", mem_we, ew);
    check("mem_wdata", mem_wdata, ewd);
    check("busy_wait", busy, 1'b1);
    mem_rdata = rdata;
    cyc = 0;
    if (d >= 0) begin
      repeat (d) begin tick(); cyc++; end
      check("mem_en_held", mem_en, 1'b1);
      check("mem_addr_held", mem_addr, ea);
      mem_resp = 1'b1;
    end
    while (!(i_ack || d_ack) && cyc < 40) begin tick(); cyc++; end
    if (d >= 0) check("ack_delay", LW'(cyc), LW'(d + 1));
    else        check("timeout_len", LW'(cyc), LW'(TO));
    if (d < 0)      m_terr = 1'b1;
    else if (!ew) begin
      if (g) m_d_line = rdata;
      else   m_i_line = rdata;
    end
    check("i_ack", i_ack, !g);
    check("d_ack", d_ack, g);
    check("mem_en_off", mem_en, 1'b0);
    check("i_line", i_line_o, m_i_line);
    check("d_line", d_line_o, m_d_line);
    check("timeout_err", timeout_err, m_terr);
    if (g) d_req = 1'b0;
    else   i_req = 1'b0;
    if (hold == 0) mem_resp = 1'b0;
    tick();
    check("ack_pulse", {i_ack, d_ack}, 2'b00);
  endtask

  // Hold mem_resp for a while in RELEASE, then let the FSM return to IDLE
  task automatic finish_release(input int hold);
    int cyc;
    for (int k = 0; k < hold; k++) begin
      check("release_busy", busy, 1'b1);
      check("release_no_en", mem_en, 1'b0);
      tick();
    end
    mem_resp = 1'b0;
    cyc = 0;
    while (busy && cyc < 10) begin tick(); cyc++; end
    check("back_idle", busy, 1'b0);
  endtask

  initial begin
    int mode;
    // Reset state
    #3 rst = 1'b0;
    tick(); tick();
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_acks", {i_ack, d_ack}, 2'b00);
    check("rst_lines", i_line_o | d_line_o, '0);
    check("rst_terr", timeout_err, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    rst = 1'b1;
    tick();

    // icache read, response three cycles after mem_en
    i_addr = 32'h0000_1234; i_req = 1'b1;
    serve(3, 0, rand_line(), 1);
    check("i_addr_align", mem_addr, 32'h0000_1220);
    finish_release(0);

    // dcache read, then write-back of a dirty line
    d_addr = $urandom; d_we = 1'b0; d_req = 1'b1;
    serve($urandom_range(0, 5), 0, rand_line(), 1);
    finish_release(0);
    d_addr = 32'h8000_00E0; d_we = 1'b1; d_wdata = rand_line(); d_req = 1'b1;
    serve(2, 0, rand_line(), 1);
    finish_release(0);
    d_we = 1'b0;

    // Spurious response in IDLE is ignored
    mem_resp = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("spurious_idle", {busy, mem_en}, 2'b00);
    end
    mem_resp = 1'b0;
    tick();

    // Response already high when WAIT is entered
    mem_resp = 1'b1;
    i_addr = $urandom; i_req = 1'b1;
    serve(0, 0, rand_line(), 1);
    finish_release(0);

    // Both caches keep requesting: grants alternate I, D, I, D
    i_addr = $urandom; d_addr = $urandom; i_req = 1'b1; d_req = 1'b1;
    for (int t = 0; t < 4; t++) begin
      serve($urandom_range(0, 4), 0, rand_line(), 0);
      i_req = 1'b1; d_req = 1'b1;
    end
    i_req = 1'b0; d_req = 1'b0;
    finish_release(0);

    // RAM keeps its response high after DONE: no new request until it drops
    i_addr = $urandom; i_req = 1'b1;
    serve(1, 5, rand_line(), 1);
    finish_release(5);

    // Random traffic
    for (int t = 0; t < 8; t++) begin
      mode    = $urandom_range(0, 2);
      i_addr  = $urandom;
      d_addr  = $urandom;
      d_we    = $urandom_range(0, 1);
      d_wdata = rand_line();
      i_req   = (mode != 1);
      d_req   = (mode != 0);
      serve($urandom_range(0, 6), 0, rand_line(), 1);
      i_req = 1'b0; d_req = 1'b0;
      finish_release(0);
    end
    d_we = 1'b0;

    // Make the tie pointer favour dcache, then reset mid-WAIT
    if (m_rr) begin
      i_req = 1'b1; d_req = 1'b1;
      serve(0, 0, rand_line(), 1);
      i_req = 1'b0; d_req = 1'b0;
      finish_release(0);
    end
    i_req = 1'b1; d_req = 1'b1;
    serve(0, 0, rand_line(), 1);
    i_req = 1'b0; d_req = 1'b0;
    finish_release(0);
    i_addr = $urandom; i_req = 1'b1;
    tick(); tick(); tick();
    check("pre_reset_wait", mem_en, 1'b1);
    rst = 1'b0;
    #1;
    check("async_rst_en", mem_en, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_acks", {i_ack, d_ack}, 2'b00);
    check("async_rst_lines", i_line_o | d_line_o, '0);
    i_req = 1'b0; mem_resp = 1'b0;
    m_rr = 1'b0; m_i_line = '0; m_d_line = '0; m_terr = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b1;
    tick();
    i_addr = $urandom; d_addr = $urandom; i_req = 1'b1; d_req = 1'b1;
    serve(1, 0, rand_line(), 1);
    i_req = 1'b0; d_req = 1'b0;
    finish_release(0);

    // Watchdog: RAM never answers
    i_addr = $urandom; i_req = 1'b1;
    serve(-1, 0, rand_line(), 1);
    finish_release(0);
    // A later normal transaction completes; the error flag stays set
    d_addr = $urandom; d_req = 1'b1;
    serve(3, 0, rand_line(), 1);
    finish_release(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
